// File: rtl/stack_tx_scheduler.sv
// stack_tx_scheduler
// Watches four 48-bit instrument stacks, queues each one when it settles on a
// new value, and sends queued stacks round-robin as framed bytes over a
// valid/ready byte interface: SYNC_BYTE, then the six stack bytes MSB first.
// Optional feature macro: FRAME_CHECKSUM_EN -- when defined, an XOR checksum
// of the six data bytes is appended as an eighth frame byte.
module stack_tx_scheduler #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hAA,
    parameter int unsigned STABLE_CYC = 2
) (
    input  logic        CLK_100KHZ,
    input  logic        RESET,
    input  logic [47:0] STACK0,
    input  logic [47:0] STACK1,
    input  logic [47:0] STACK2,
    input  logic [47:0] STACK3,
    input  logic [3:0]  SRC_EN,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic [1:0]  CUR_SRC,
    output logic [3:0]  OVERRUN
);

    localparam int DATA_W = 48;
    localparam logic [3:0] STABLE_W = STABLE_CYC[3:0];

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_SYNC  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
`ifdef FRAME_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd5;
`endif
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [DATA_W-1:0] stack_in [4];
    logic [DATA_W-1:0] stack_p0 [4];   // input sample
    logic [DATA_W-1:0] stack_p1 [4];   // previous sample
    logic [DATA_W-1:0] shadow   [4];   // last value declared new
    logic [3:0]        run      [4];   // consecutive identical samples
    logic [3:0]        run_nxt  [4];
    logic [3:0]        new_stk;

    logic [3:0]        pending;
    logic [3:0]        elig;
    logic [3:0]        clr;
    logic [1:0]        rr;
    logic [1:0]        pick;
    logic              pick_ok;
    logic [1:0]        idx;
    logic [1:0]        sel;

    logic [2:0]        state;
    logic [DATA_W-1:0] txbuf;
    logic [2:0]        byte_cnt;
    logic              busy_r;
    logic [1:0]        cur_src_r;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        chk;
`endif

    assign stack_in[0] = STACK0;
    assign stack_in[1] = STACK1;
    assign stack_in[2] = STACK2;
    assign stack_in[3] = STACK3;

    assign BUSY    = busy_r;
    assign CUR_SRC = cur_src_r;

    // Stability counter and new-stack detection: a sample that differs from the
    // shadow only counts once it has been seen unchanged STABLE_CYC times, which
    // hides the skew of the slow-domain writer updating the stack piecewise.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (stack_p0[i] != stack_p1[i]) begin
                run_nxt[i] = 4'd1;
            end else if (run[i] != 4'hF) begin
                run_nxt[i] = run[i] + 4'd1;
            end else begin
                run_nxt[i] = run[i];
            end
            new_stk[i] = (stack_p0[i] != shadow[i]) && (run_nxt[i] >= STABLE_W);
        end
    end

    // Sample the stacks, track stability and capture settled values.
    always_ff @(posedge CLK_100KHZ or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                stack_p0[i] <= '0;
                stack_p1[i] <= '0;
                shadow[i]   <= '0;
                run[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                stack_p0[i] <= stack_in[i];
                stack_p1[i] <= stack_p0[i];
                run[i]      <= run_nxt[i];
                if (new_stk[i]) begin
                    shadow[i] <= stack_p0[i];
                end
            end
        end
    end

    // Round-robin pick: the eligible source at the smallest offset from rr wins.
    // The loop runs from the largest offset down so the last hit is the nearest.
    always_comb begin
        elig    = pending & SRC_EN;
        pick    = rr;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr + k[1:0];
            if (elig[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
        clr = (state == S_LATCH) ? (4'b0001 << sel) : 4'b0000;
    end

    // Pending and sticky overrun flags. A new stack arriving in the very cycle
    // its predecessor is latched is not an overrun: the old one is not lost,
    // and set beats clear so the new one goes out in a later frame.
    always_ff @(posedge CLK_100KHZ or negedge RESET) begin
        if (!RESET) begin
            pending <= '0;
            OVERRUN <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!SRC_EN[i]) begin
                    pending[i] <= 1'b0;
                end else if (new_stk[i]) begin
                    pending[i] <= 1'b1;
                    if (pending[i] && !clr[i]) begin
                        OVERRUN[i] <= 1'b1;
                    end
                end else if (clr[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Frame sequencer: arbitrate, latch the chosen shadow, then walk the frame
    // bytes, advancing only on an accepted handshake.
    always_ff @(posedge CLK_100KHZ or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            sel       <= '0;
            rr        <= '0;
            txbuf     <= '0;
            byte_cnt  <= '0;
            busy_r    <= 1'b0;
            cur_src_r <= '0;
`ifdef FRAME_CHECKSUM_EN
            chk       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Looking at new_stk as well saves a cycle of start latency.
                    if (|(elig | (new_stk & SRC_EN))) begin
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (pick_ok) begin
                        sel   <= pick;
                        state <= S_LATCH;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LATCH: begin
                    txbuf     <= shadow[sel];
                    cur_src_r <= sel;
                    rr        <= sel + 2'd1;
                    busy_r    <= 1'b1;
                    byte_cnt  <= '0;
`ifdef FRAME_CHECKSUM_EN
                    chk       <= '0;
`endif
                    state     <= S_SYNC;
                end
                S_SYNC: begin
                    if (TX_READY) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (TX_READY) begin
`ifdef FRAME_CHECKSUM_EN
                        chk   <= chk ^ txbuf[DATA_W-1 -: 8];
`endif
                        txbuf <= {txbuf[DATA_W-9:0], 8'h00};
                        if (byte_cnt == 3'd5) begin
`ifdef FRAME_CHECKSUM_EN
                            state  <= S_CHK;
`else
                            state  <= S_DONE;
                            busy_r <= 1'b0;
`endif
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CHK: begin
                    if (TX_READY) begin
                        state  <= S_DONE;
                        busy_r <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte offer decoded from state so an async reset drops TX_VALID at once;
    // all sources are registers, so the byte holds steady through a stall.
    always_comb begin
        TX_VALID = 1'b0;
        TX_DATA  = 8'h00;
        case (state)
            S_SYNC: begin
                TX_VALID = 1'b1;
                TX_DATA  = SYNC_BYTE;
            end
            S_DATA: begin
                TX_VALID = 1'b1;
                TX_DATA  = txbuf[DATA_W-1 -: 8];
            end
`ifdef FRAME_CHECKSUM_EN
            S_CHK: begin
                TX_VALID = 1'b1;
                TX_DATA  = chk;
            end
`endif
            default: begin
                TX_VALID = 1'b0;
                TX_DATA  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_tx_scheduler.sv
// Directed bench for stack_tx_scheduler. Frame length follows FRAME_CHECKSUM_EN.
module tb_stack_tx_scheduler;

    logic        CLK_100KHZ = 1'b0;
    logic        RESET;
    logic [47:0] STACK0, STACK1, STACK2, STACK3;
    logic [3:0]  SRC_EN;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;
    logic [1:0]  CUR_SRC;
    logic [3:0]  OVERRUN;

    int checks   = 0;
    int failures = 0;

    always #5 CLK_100KHZ = ~CLK_100KHZ;

    stack_tx_scheduler #(.SYNC_BYTE(8'hAA), .STABLE_CYC(2)) dut (
        .CLK_100KHZ (CLK_100KHZ),
        .RESET      (RESET),
        .STACK0     (STACK0),
        .STACK1     (STACK1),
        .STACK2     (STACK2),
        .STACK3     (STACK3),
        .SRC_EN     (SRC_EN),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .BUSY       (BUSY),
        .CUR_SRC    (CUR_SRC),
        .OVERRUN    (OVERRUN)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_100KHZ);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},   TX_VALID, 0);
        chk({tag, "_data"},    TX_DATA,  0);
        chk({tag, "_busy"},    BUSY,     0);
        chk({tag, "_cursrc"},  CUR_SRC,  0);
        chk({tag, "_overrun"}, OVERRUN,  0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        STACK0 = '0; STACK1 = '0; STACK2 = '0; STACK3 = '0;
        SRC_EN = 4'hF;
        TX_READY = 1'b1;
        tick(2);
        chk_reset_outputs("reset");
        RESET = 1'b1;
        tick(1);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (TX_VALID !== 1'b1 && n < max) begin
            @(negedge CLK_100KHZ);
            n++;
        end
        chk(tag, TX_VALID, 1);
    endtask

    task automatic idle_check(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            @(negedge CLK_100KHZ);
            if (TX_VALID === 1'b1) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    // Receive one frame of stk from source src; optionally stall 20 cycles on
    // frame byte stall_idx.
    task automatic recv_frame(input string tag, input logic [47:0] stk,
                              input logic [1:0] src, input int stall_idx);
        logic [7:0] exp [8];
        logic [7:0] x;
        int nb;
        exp[0] = 8'hAA;
        x = 8'h00;
        for (int j = 0; j < 6; j++) begin
            exp[j+1] = stk[47-8*j -: 8];
            x = x ^ exp[j+1];
        end
        exp[7] = x;
`ifdef FRAME_CHECKSUM_EN
        nb = 8;
`else
        nb = 7;
`endif
        TX_READY = 1'b1;
        for (int k = 0; k < nb; k++) begin
            wait_valid({tag, "_valid"}, 40);
            chk({tag, "_byte"}, TX_DATA, exp[k]);
            chk({tag, "_busy"}, BUSY, 1);
            if (k == stall_idx) begin
                TX_READY = 1'b0;
                for (int s = 0; s < 20; s++) begin
                    @(negedge CLK_100KHZ);
                    chk({tag, "_stall_data"},  TX_DATA,  exp[k]);
                    chk({tag, "_stall_valid"}, TX_VALID, 1);
                end
                TX_READY = 1'b1;
            end
            @(negedge CLK_100KHZ);
        end
        chk({tag, "_end_valid"}, TX_VALID, 0);
        chk({tag, "_end_busy"},  BUSY,     0);
        chk({tag, "_cursrc"},    CUR_SRC,  src);
    endtask

    logic [7:0] t1 [8];
    logic [7:0] t6 [6];
    int t1_n;

    initial begin
        // ---- Test 1: single source-0 frame, exact start latency ----
        do_reset();
        STACK0 = 48'h0001_0001_2347;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            chk("t1_lead_valid", TX_VALID, 0);
            chk("t1_lead_busy",  BUSY,     0);
        end
        tick(1);
        chk("t1_first_valid", TX_VALID, 1);
        t1 = '{8'hAA, 8'h00, 8'h01, 8'h00, 8'h01, 8'h23, 8'h47, 8'h64};
`ifdef FRAME_CHECKSUM_EN
        t1_n = 8;
`else
        t1_n = 7;
`endif
        for (int k = 0; k < t1_n; k++) begin
            chk("t1_valid", TX_VALID, 1);
            chk("t1_byte",  TX_DATA,  t1[k]);
            chk("t1_busy",  BUSY,     1);
            tick(1);
        end
        chk("t1_done_valid", TX_VALID, 0);
        chk("t1_done_busy",  BUSY,     0);
        chk("t1_cursrc",     CUR_SRC,  0);
        idle_check("t1_no_repeat", 10);

        // ---- Test 2: all four change together, then 2 and 0 together ----
        do_reset();
        STACK0 = 48'h1020_3040_5000;
        STACK1 = 48'hA1B2_C3D4_E501;
        STACK2 = 48'h0F1E_2D3C_4B02;
        STACK3 = 48'hFFEE_DDCC_BB03;
        recv_frame("t2_f0", 48'h1020_3040_5000, 2'd0, -1);
        recv_frame("t2_f1", 48'hA1B2_C3D4_E501, 2'd1, -1);
        recv_frame("t2_f2", 48'h0F1E_2D3C_4B02, 2'd2, -1);
        recv_frame("t2_f3", 48'hFFEE_DDCC_BB03, 2'd3, -1);
        STACK2 = 48'h1234_5678_9A02;
        STACK0 = 48'h5555_6666_7700;
        recv_frame("t2_g0", 48'h5555_6666_7700, 2'd0, -1);
        recv_frame("t2_g2", 48'h1234_5678_9A02, 2'd2, -1);

        // ---- Test 3: 20-cycle stall on a data byte ----
        STACK1 = 48'hCAFE_F00D_BE01;
        recv_frame("t3", 48'hCAFE_F00D_BE01, 2'd1, 3);
        idle_check("t3_idle", 15);

        // ---- Test 4: overrun on source 1 while source 0 is stalled ----
        do_reset();
        TX_READY = 1'b0;
        STACK0 = 48'h0A0B_0C0D_0E00;
        wait_valid("t4_sync", 40);
        tick(1);
        chk("t4_stalled_sync", TX_DATA, 8'hAA);
        STACK1 = 48'h1111_1111_1101;
        tick(6);
        chk("t4_overrun_first", OVERRUN, 4'b0000);
        STACK1 = 48'h2222_2222_2201;
        tick(6);
        chk("t4_overrun_second", OVERRUN, 4'b0010);
        recv_frame("t4_f0", 48'h0A0B_0C0D_0E00, 2'd0, -1);
        recv_frame("t4_f1", 48'h2222_2222_2201, 2'd1, -1);
        idle_check("t4_single_f1", 15);
        chk("t4_overrun_sticky", OVERRUN, 4'b0010);

        // ---- Test 5: glitch filtered; disabled source not queued ----
        STACK3 = 48'h7777_7777_7703;
        tick(1);
        STACK3 = 48'h0;
        idle_check("t5_glitch", 15);
        SRC_EN = 4'b0111;
        STACK3 = 48'h3333_3333_3303;
        tick(6);
        STACK3 = 48'h4444_4444_4403;
        tick(6);
        idle_check("t5_disabled", 10);
        chk("t5_overrun3", OVERRUN, 4'b0010);
        SRC_EN = 4'hF;
        idle_check("t5_reenable", 15);

        // ---- Test 6: async reset during data byte 3 ----
        STACK2 = 48'h9988_7766_5502;
        t6 = '{8'hAA, 8'h99, 8'h88, 8'h77, 8'h66, 8'h55};
        TX_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("t6_valid", 40);
            chk("t6_byte", TX_DATA, t6[k]);
            tick(1);
        end
        wait_valid("t6_valid_b3", 40);
        chk("t6_byte3", TX_DATA, t6[4]);
        chk("t6_cursrc_pre", CUR_SRC, 2);
        RESET = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        STACK0 = '0; STACK1 = '0; STACK2 = '0; STACK3 = '0;
        tick(2);
        RESET = 1'b1;
        idle_check("t6_no_frame", 20);
        chk_reset_outputs("t6_after");
        STACK1 = 48'hBEEF_0000_1201;
        recv_frame("t6_recover", 48'hBEEF_0000_1201, 2'd1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
